// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// and latency/error classification helpers.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011,
        OP_REM = 4'b0100,
        OP_AND = 4'b0101,
        OP_OR  = 4'b0110,
        OP_XOR = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRL = 4'b1001,
        OP_SLT = 4'b1010
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Multi-cycle ops take MULDIV_LAT execute cycles; everything else takes one.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_SLT;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: contention goes to the requester not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;

    assign grant = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;

    // Pointer starts at requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional rsp_err output for unused opcodes is enabled by ALU_ARB_ERR_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    input  logic             alu_ovf,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_ovf
`ifdef ALU_ARB_ERR_EN
    ,
    output logic             rsp_err
`endif
);

    localparam logic [3:0] MD_LAT = 4'(MULDIV_LAT);

    state_t           state;
    logic [1:0]       grant;
    logic             accept;
    logic [3:0]       op_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign req0_ready = (state == S_IDLE) && grant[0];
    assign req1_ready = (state == S_IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;

    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

    always_comb begin
        // NOTE: assign every output first so no path leaves it unassigned (no latch).
        sel_op = req0_op;
        sel_a  = req0_a;
        sel_b  = req0_b;
        if (grant[1]) begin
            sel_op = req1_op;
            sel_a  = req1_a;
            sel_b  = req1_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            cnt_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_sign  <= 1'b0;
            rsp_ovf   <= 1'b0;
`ifdef ALU_ARB_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= sel_op;
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= grant[1];
                        cnt_q <= is_muldiv(sel_op) ? MD_LAT : 4'd1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands stay in a_q/b_q/op_q until the final cycle captures the result.
                    if (cnt_q == 4'd1) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_q;
                        rsp_data  <= alu_result;
                        rsp_zero  <= alu_zero;
                        rsp_sign  <= alu_sign;
                        rsp_ovf   <= alu_ovf;
`ifdef ALU_ARB_ERR_EN
                        rsp_err   <= is_illegal(op_q);
`endif
                        state     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// round-robin traffic against a behavioural model of arbitration and the ALU.
module tb_alu_arbiter;

    localparam int W   = 32;
    localparam int LAT = 4;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         s;
        logic         o;
    } alu_out_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_a, alu_b, alu_result, rsp_data;
    logic         alu_zero, alu_sign, alu_ovf;
    logic         rsp_valid, rsp_id, rsp_zero, rsp_sign, rsp_ovf;
`ifdef ALU_ARB_ERR_EN
    logic         rsp_err;
`endif
    alu_out_t     alu_o;

    int           total = 0;
    int           bad   = 0;
    bit           pend_v  [2];
    logic [3:0]   pend_op [2];
    logic [W-1:0] pend_a  [2];
    logic [W-1:0] pend_b  [2];
    int           last_grant;

    alu_arbiter #(.WIDTH(W), .MULDIV_LAT(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_sign   (alu_sign),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_sign   (rsp_sign),
        .rsp_ovf    (rsp_ovf)
`ifdef ALU_ARB_ERR_EN
        ,
        .rsp_err    (rsp_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_out_t res;
        res.o = 1'b0;
        case (op)
            4'd0:  begin res.r = a + b; res.o = (a[W-1] == b[W-1]) && (res.r[W-1] != a[W-1]); end
            4'd1:  begin res.r = a - b; res.o = (a[W-1] != b[W-1]) && (res.r[W-1] != a[W-1]); end
            4'd2:  res.r = a * b;
            4'd3:  res.r = (b == 0) ? '1 : a / b;
            4'd4:  res.r = (b == 0) ? a : a % b;
            4'd5:  res.r = a & b;
            4'd6:  res.r = a | b;
            4'd7:  res.r = a ^ b;
            4'd8:  res.r = a << b[4:0];
            4'd9:  res.r = a >> b[4:0];
            4'd10: res.r = ($signed(a) < $signed(b)) ? 1 : 0;
            default: res.r = '0;
        endcase
        res.z = (res.r == 0);
        res.s = res.r[W-1];
        return res;
    endfunction

    // Stand-in for the shared ALU the arbiter drives.
    always_comb alu_o = alu_fn(alu_op, alu_a, alu_b);
    assign alu_result = alu_o.r;
    assign alu_zero   = alu_o.z;
    assign alu_sign   = alu_o.s;
    assign alu_ovf    = alu_o.o;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle requesters carry junk operands so the held ALU inputs are meaningful.
    task automatic drive();
        req0_valid = pend_v[0];
        req0_op    = pend_v[0] ? pend_op[0] : 4'($urandom);
        req0_a     = pend_v[0] ? pend_a[0]  : $urandom;
        req0_b     = pend_v[0] ? pend_b[0]  : $urandom;
        req1_valid = pend_v[1];
        req1_op    = pend_v[1] ? pend_op[1] : 4'($urandom);
        req1_a     = pend_v[1] ? pend_a[1]  : $urandom;
        req1_b     = pend_v[1] ? pend_b[1]  : $urandom;
    endtask

    task automatic set_req(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        pend_v[n]  = 1'b1;
        pend_op[n] = op;
        pend_a[n]  = a;
        pend_b[n]  = b;
    endtask

    function automatic int predict();
        if (pend_v[0] && pend_v[1]) return 1 - last_grant;
        return pend_v[0] ? 0 : 1;
    endfunction

    // Called just after a negedge in IDLE with at least one request pending.
    task automatic serve();
        int           w;
        int           n;
        int           lat;
        logic [3:0]   op;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        alu_out_t     e;
        w   = predict();
        op  = pend_op[w];
        ea  = pend_a[w];
        eb  = pend_b[w];
        e   = alu_fn(op, ea, eb);
        lat = (op >= 4'd2 && op <= 4'd4) ? LAT : 1;
        drive();
        #1;
        check("ready0_idle", 64'(req0_ready), 64'(w == 0));
        check("ready1_idle", 64'(req1_ready), 64'(w == 1));
        @(posedge clk);
        @(negedge clk);
        pend_v[w]  = 1'b0;
        last_grant = w;
        drive();
        #1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            check("ready_exec", 64'({req1_ready, req0_ready}), 64'd0);
            check("alu_a_hold", 64'(alu_a), 64'(ea));
            check("alu_b_hold", 64'(alu_b), 64'(eb));
            check("alu_op_hold", 64'(alu_op), 64'(op));
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("rsp_data", 64'(rsp_data), 64'(e.r));
        check("rsp_id", 64'(rsp_id), 64'(w));
        check("rsp_zero", 64'(rsp_zero), 64'(e.z));
        check("rsp_sign", 64'(rsp_sign), 64'(e.s));
        check("rsp_ovf", 64'(rsp_ovf), 64'(e.o));
`ifdef ALU_ARB_ERR_EN
        check("rsp_err", 64'(rsp_err), 64'(op > 4'd10));
`endif
        check("ready_resp", 64'({req1_ready, req0_ready}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rsp_pulse", 64'(rsp_valid), 64'd0);
        check("rsp_hold", 64'(rsp_data), 64'(e.r));
    endtask

    initial begin
        reset      = 1'b0;
        pend_v[0]  = 1'b0;
        pend_v[1]  = 1'b0;
        last_grant = 1;
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_op", 64'(alu_op), 64'd0);
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);

        // Single add from requester 0 right after reset release.
        set_req(0, 4'd0, 32'd5, 32'd7);
        reset = 1'b1;
        serve();
        check("t1_data", 64'(rsp_data), 64'd12);
        check("t1_zero", 64'(rsp_zero), 64'd0);

        // Multi-cycle multiply from requester 1.
        set_req(1, 4'd2, 32'd6, 32'd7);
        serve();
        check("t3_data", 64'(rsp_data), 64'd42);
        check("t3_id", 64'(rsp_id), 64'd1);

        // Contention: requester 0 wins, requester 1 stays pending and follows.
        set_req(0, 4'd1, 32'd3, 32'd3);
        set_req(1, 4'd6, 32'h0000_00F0, 32'h0000_000F);
        serve();
        check("t2a_data", 64'(rsp_data), 64'd0);
        check("t2a_zero", 64'(rsp_zero), 64'd1);
        check("t2a_id", 64'(rsp_id), 64'd0);
        serve();
        check("t2b_data", 64'(rsp_data), 64'h0000_00FF);
        check("t2b_id", 64'(rsp_id), 64'd1);

        // Unused opcode.
        set_req(1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
        serve();
        check("t5_data", 64'(rsp_data), 64'd0);
`ifdef ALU_ARB_ERR_EN
        check("t5_err", 64'(rsp_err), 64'd1);
`endif

        // Signed overflow on add.
        set_req(0, 4'd0, 32'h7FFF_FFFF, 32'd1);
        serve();
        check("t4_data", 64'(rsp_data), 64'h8000_0000);
        check("t4_sign", 64'(rsp_sign), 64'd1);
        check("t4_ovf", 64'(rsp_ovf), 64'd1);

        // Reset in the middle of a multiply aborts it without a response.
        set_req(0, 4'd2, 32'd9, 32'd9);
        drive();
        #1;
        check("t6_ready0", 64'(req0_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        pend_v[0] = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_rsp_data", 64'(rsp_data), 64'd0);
        check("t6_alu_a", 64'(alu_a), 64'd0);
        check("t6_alu_b", 64'(alu_b), 64'd0);
        check("t6_alu_op", 64'(alu_op), 64'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t6_no_rsp", 64'(rsp_valid), 64'd0);
        end
        set_req(0, 4'd0, 32'd1, 32'd1);
        set_req(1, 4'd0, 32'd2, 32'd2);
        last_grant = 1;
        reset = 1'b1;
        serve();
        check("t6_first_id", 64'(rsp_id), 64'd0);
        serve();
        check("t6_second_data", 64'(rsp_data), 64'd4);

        // Randomized traffic; unserved requests stay pending across iterations.
        for (int it = 0; it < 60; it++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend_v[n] && $urandom_range(0, 1) == 1) begin
                    set_req(n, 4'($urandom_range(0, 15)),
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom);
                end
            end
            if (!pend_v[0] && !pend_v[1]) begin
                set_req(it % 2, 4'($urandom_range(0, 10)), $urandom, $urandom);
            end
            serve();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
